// File: rtl/iterative_alu_pkg.sv
// Shared definitions for the iterative ALU: opcodes, flag bit positions, FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package alu_defs;

   // Opcode map (5-bit); any code not listed here is illegal.
   localparam logic [4:0] OP_NOP  = 5'b00000;
   localparam logic [4:0] OP_ADD  = 5'b00001;
   localparam logic [4:0] OP_SUB  = 5'b00010;
   localparam logic [4:0] OP_MUL  = 5'b00011;
   localparam logic [4:0] OP_DIV  = 5'b00100;
   localparam logic [4:0] OP_SHL  = 5'b00101;
   localparam logic [4:0] OP_SHR  = 5'b00110;
   localparam logic [4:0] OP_ROL  = 5'b00111;
   localparam logic [4:0] OP_ROR  = 5'b01000;
   localparam logic [4:0] OP_AND  = 5'b01001;
   localparam logic [4:0] OP_XOR  = 5'b01011;
   localparam logic [4:0] OP_OR   = 5'b01101;
   localparam logic [4:0] OP_NAND = 5'b01110;
   localparam logic [4:0] OP_XNOR = 5'b01111;
   localparam logic [4:0] OP_GTH  = 5'b10000;
   localparam logic [4:0] OP_EQU  = 5'b10001;

   // Bit positions inside the Flags vector.
   localparam int FLAG_Z = 0;
   localparam int FLAG_C = 1;
   localparam int FLAG_N = 2;
   localparam int FLAG_E = 3;

   // Control FSM: EXEC for one-cycle ops, ITER while mul/div steps, DONE to capture.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_ITER = 2'd2,
      ST_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/iterative_alu_if.sv
// Request/result bundle between the instruction decoder and the iterative ALU.
// Latency: n/a (wiring only).
// Backpressure: Start is honoured only while Ready=1; nothing is queued.
interface iterative_alu_if #(
   parameter int WIDTH           = 8,
   parameter int INSTR_BIT_WIDTH = 5,
   parameter int FLAGS_COUNT     = 4
);
   logic                       Start;
   logic [INSTR_BIT_WIDTH-1:0] Instruction;
   logic [WIDTH-1:0]           InputA;
   logic [WIDTH-1:0]           InputB;
   logic [WIDTH-1:0]           ResultA;
   logic [WIDTH-1:0]           ResultB;
   logic [FLAGS_COUNT-1:0]     Flags;
   logic                       Ready;

   // Requester side (decoder / bench).
   modport master (
      output Start, Instruction, InputA, InputB,
      input  ResultA, ResultB, Flags, Ready
   );

   // ALU side.
   modport slave (
      input  Start, Instruction, InputA, InputB,
      output ResultA, ResultB, Flags, Ready
   );
endinterface

// File: rtl/iterative_alu_muldiv.sv
// Shift-add multiplier / restoring divider sharing one 2*WIDTH accumulator and step counter.
// Latency: Go at edge k, WIDTH steps on edges k+1..k+WIDTH; Done is high during the last step cycle.
// Backpressure: none; a Go restarts the unit, the caller guarantees one op in flight.
module iterative_muldiv #(
   parameter int WIDTH = 8
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Go,
   input  logic             IsDiv,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo,
   output logic             Done
);
   localparam int CW = $clog2(WIDTH) + 1;

   // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_nxt;
   logic [WIDTH-1:0]   opnd;
   logic               is_div;
   logic               run;
   logic [CW-1:0]      cnt;
   logic [WIDTH:0]     add_t;
   logic [WIDTH:0]     rem_t;
   logic [WIDTH:0]     sub_t;

   assign Hi   = acc[2*WIDTH-1:WIDTH];
   assign Lo   = acc[WIDTH-1:0];
   assign Done = run && (cnt == CW'(WIDTH - 1));

   // One multiply or divide step; the extra top bit of add_t/sub_t is carry/borrow.
   always_comb begin
      add_t = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
      rem_t = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      sub_t = rem_t - {1'b0, opnd};
      if (is_div) begin
         if (!sub_t[WIDTH]) begin
            acc_nxt = {sub_t[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
         end else begin
            acc_nxt = {rem_t[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
         end
      end else if (acc[0]) begin
         acc_nxt = {add_t, acc[WIDTH-1:1]};
      end else begin
         acc_nxt = {1'b0, acc[2*WIDTH-1:1]};
      end
   end

   // Load on Go, then step until the counter reaches WIDTH; counter never wraps within one op.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         acc    <= '0;
         opnd   <= '0;
         is_div <= 1'b0;
         run    <= 1'b0;
         cnt    <= '0;
      end else if (Go) begin
         acc    <= {{WIDTH{1'b0}}, A};
         opnd   <= B;
         is_div <= IsDiv;
         run    <= 1'b1;
         cnt    <= '0;
      end else if (run) begin
         acc <= acc_nxt;
         cnt <= cnt + 1'b1;
         if (Done) begin
            run <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/iterative_alu.sv
// Multi-cycle ALU: one-cycle logic/arith/shift ops plus iterative MUL/DIV with double-width results.
// Latency: 1 busy cycle for single-cycle ops, NOP, illegal and DIV-by-0; WIDTH+1 for MUL/DIV.
// Backpressure: Ready=0 while busy; Start is ignored (not queued) until Ready returns to 1.
module iterative_alu #(
   parameter int WIDTH           = 8,
   parameter int INSTR_BIT_WIDTH = 5,
   parameter int FLAGS_COUNT     = 4
) (
   input logic           Clk,
   input logic           Rst,
   iterative_alu_if.slave bus
);
   import alu_defs::*;

   localparam int SHW = $clog2(WIDTH);

   state_e                 state;
   logic [4:0]             op_q;
   logic                   op_bad_q;
   logic [WIDTH-1:0]       a_q;
   logic [WIDTH-1:0]       b_q;
   logic [WIDTH-1:0]       res_a;
   logic [WIDTH-1:0]       res_b;
   logic [FLAGS_COUNT-1:0] flags;
   logic                   ready;

   logic [4:0]             in_op;
   logic                   in_op_hi;
   logic                   in_iter;
   logic                   md_go;
   logic [WIDTH-1:0]       md_hi;
   logic [WIDTH-1:0]       md_lo;
   logic                   md_done;

   logic [WIDTH:0]         sum;
   logic [WIDTH:0]         diff;
   logic [SHW-1:0]         amt;
   logic [WIDTH-1:0]       ex_a;
   logic [WIDTH-1:0]       ex_b;
   logic                   ex_c;
   logic                   ex_e;
   logic                   ex_nop;
   logic                   ex_illegal;

   assign bus.ResultA = res_a;
   assign bus.ResultB = res_b;
   assign bus.Flags   = flags;
   assign bus.Ready   = ready;

   // Opcode bits above the 5-bit map make the instruction illegal.
   assign in_op = bus.Instruction[4:0];
   generate
      if (INSTR_BIT_WIDTH > 5) begin : g_wide_op
         assign in_op_hi = |bus.Instruction[INSTR_BIT_WIDTH-1:5];
      end else begin : g_narrow_op
         assign in_op_hi = 1'b0;
      end
   endgenerate

   // DIV by zero takes the one-cycle path so it never starts the iterator.
   assign in_iter = !in_op_hi && ((in_op == OP_MUL) || ((in_op == OP_DIV) && (bus.InputB != '0)));
   assign md_go   = (state == ST_IDLE) && bus.Start && in_iter;

   iterative_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .Clk   (Clk),
      .Rst   (Rst),
      .Go    (md_go),
      .IsDiv (in_op == OP_DIV),
      .A     (bus.InputA),
      .B     (bus.InputB),
      .Hi    (md_hi),
      .Lo    (md_lo),
      .Done  (md_done)
   );

   function automatic logic [FLAGS_COUNT-1:0] mk_flags(input logic [WIDTH-1:0] r,
                                                       input logic c, input logic e);
      mk_flags         = '0;
      mk_flags[FLAG_Z] = (r == '0);
      mk_flags[FLAG_C] = c;
      mk_flags[FLAG_N] = r[WIDTH-1];
      mk_flags[FLAG_E] = e;
   endfunction

   function automatic logic [WIDTH-1:0] rot_l(input logic [WIDTH-1:0] x, input logic [SHW-1:0] n);
      rot_l = '0;
      for (int i = 0; i < WIDTH; i++) rot_l[(i + int'(n)) % WIDTH] = x[i];
   endfunction

   function automatic logic [WIDTH-1:0] rot_r(input logic [WIDTH-1:0] x, input logic [SHW-1:0] n);
      rot_r = '0;
      for (int i = 0; i < WIDTH; i++) rot_r[i] = x[(i + int'(n)) % WIDTH];
   endfunction

   // Single-cycle datapath on the latched operands.
   always_comb begin
      sum        = {1'b0, a_q} + {1'b0, b_q};
      diff       = {1'b0, a_q} - {1'b0, b_q};
      amt        = b_q[SHW-1:0];
      ex_a       = res_a;
      ex_b       = '0;
      ex_c       = 1'b0;
      ex_e       = 1'b0;
      ex_nop     = 1'b0;
      ex_illegal = 1'b0;
      if (op_bad_q) begin
         ex_illegal = 1'b1;
      end else begin
         case (op_q)
            OP_NOP:  ex_nop = 1'b1;
            OP_ADD:  begin ex_a = sum[WIDTH-1:0];  ex_c = sum[WIDTH];  end
            OP_SUB:  begin ex_a = diff[WIDTH-1:0]; ex_c = diff[WIDTH]; end
            OP_DIV:  begin ex_a = '1; ex_b = a_q; ex_e = 1'b1; end
            OP_SHL:  ex_a = a_q << amt;
            OP_SHR:  ex_a = a_q >> amt;
            OP_ROL:  ex_a = rot_l(a_q, amt);
            OP_ROR:  ex_a = rot_r(a_q, amt);
            OP_AND:  ex_a = a_q & b_q;
            OP_XOR:  ex_a = a_q ^ b_q;
            OP_OR:   ex_a = a_q | b_q;
            OP_NAND: ex_a = ~(a_q & b_q);
            OP_XNOR: ex_a = ~(a_q ^ b_q);
            OP_GTH:  ex_a = (a_q > b_q)  ? '1 : '0;
            OP_EQU:  ex_a = (a_q == b_q) ? '1 : '0;
            // MUL never reaches EXEC; treating it as illegal keeps the decode total.
            default: ex_illegal = 1'b1;
         endcase
      end
   end

   // Control FSM with registered results, flags and Ready.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state    <= ST_IDLE;
         op_q     <= OP_NOP;
         op_bad_q <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         res_a    <= '0;
         res_b    <= '0;
         flags    <= '0;
         ready    <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.Start) begin
                  op_q     <= in_op;
                  op_bad_q <= in_op_hi;
                  a_q      <= bus.InputA;
                  b_q      <= bus.InputB;
                  ready    <= 1'b0;
                  state    <= in_iter ? ST_ITER : ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (ex_illegal) begin
                  flags[FLAG_E] <= 1'b1;
               end else if (!ex_nop) begin
                  res_a <= ex_a;
                  res_b <= ex_b;
                  flags <= mk_flags(ex_a, ex_c, ex_e);
               end
               ready <= 1'b1;
               state <= ST_IDLE;
            end
            ST_ITER: begin
               if (md_done) begin
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               res_a <= md_lo;
               res_b <= md_hi;
               flags <= mk_flags(md_lo, (op_q == OP_MUL) && (md_hi != '0), 1'b0);
               ready <= 1'b1;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/iterative_alu.md
# iterative_alu

Parametrised multi-cycle ALU, next generation of the simple ALU. Adds a width parameter, an explicit Start/Ready handshake, iterative shift-add multiply and restoring divide with double-width results, and a full flag set. Sits between the instruction decoder and the register file; one operation in flight at a time.

## Interface
- WIDTH, 8, operand/result width (≥4, power of two)
- INSTR_BIT_WIDTH, 5, opcode width
- FLAGS_COUNT, 4, flag vector width (fixed layout below)
- Clk  in  1  single clock, rising edge
- Rst  in  1  reset, asynchronous, active-high
- Start  in  1  request; accepted only on an edge where Ready=1
- Instruction  in  INSTR_BIT_WIDTH  opcode, sampled with Start
- InputA, InputB  in  WIDTH  unsigned operands, sampled with Start
- ResultA  out  WIDTH  primary result / low product / quotient
- ResultB  out  WIDTH  high product / remainder / 0
- Flags  out  FLAGS_COUNT  [0]=Z, [1]=C, [2]=N (ResultA MSB), [3]=E (error)
- Ready  out  1  1 = idle, results valid; 0 = busy

## Operation
- Opcodes: NOP 00000, ADD 00001, SUB 00010, MUL 00011, DIV 00100, SHL 00101, SHR 00110, ROL 00111, ROR 01000, AND 01001, XOR 01011, OR 01101, NAND 01110, XNOR 01111, GTH 10000, EQU 10001.
- States: IDLE (Ready=1), EXEC (single-cycle ops), ITER (MUL/DIV), DONE → IDLE.
- IDLE + Start: latch operands/opcode; MUL/DIV with nonzero divisor → ITER; otherwise → EXEC.
- ADD: C = carry out. SUB: A−B mod 2^WIDTH, C = borrow (A<B).
- Shifts/rotates: amount = InputB[$clog2(WIDTH)-1:0]; SHL/SHR zero-fill; C = 0.
- GTH: ResultA = all ones if A>B, else 0. EQU: all ones if A==B, else 0.
- Logic/compare/shift ops: ResultB = 0.
- MUL: {ResultB,ResultA} = A×B (2·WIDTH bits), one partial-product step per cycle. C = (ResultB≠0).
- DIV: ResultA = A/B, ResultB = A%B, one restoring step per cycle.
- DIV with B=0: no iteration; ResultA = all ones, ResultB = A, E=1.
- Illegal opcode: results unchanged, E=1. NOP: results and flags unchanged, handshake still completes.
- Z = (ResultA==0) for every op updating results; E cleared on every other accepted op.
- Outputs held stable while Ready=1 until the next accepted Start.

## Timing
- Reset: ResultA=0, ResultB=0, Flags=0, Ready=1, state IDLE, iteration counter 0.
- Start accepted at edge k: Ready=0 after edge k.
- Single-cycle ops, NOP, illegal, DIV-by-zero: results, flags and Ready=1 after edge k+1 (1 busy cycle).
- MUL/DIV: Ready=1 after edge k+WIDTH+1 (WIDTH iteration cycles + 1 finalise cycle).
- Start while Ready=0: ignored, no queuing; inputs may change freely while busy.
- Start held high across completion: re-accepted on the first edge with Ready=1 (back-to-back ops, one idle cycle visible per op).
- Rst mid-operation: immediate abort to reset values; no partial result escapes.
- Iteration counter $clog2(WIDTH)+1 bits; no wrap within one op.

## Structure
- Package alu_defs: opcode constants, flag index constants (FLAG_Z/C/N/E), state encoding.
- Sub-module iterative_muldiv (WIDTH param): shift-add multiplier and restoring divider sharing one 2·WIDTH accumulator and counter; ports Clk, Rst, Go, IsDiv, A, B, Hi, Lo, Done.
- Top holds the FSM, single-cycle datapath, flag generation and output registers.

## Test plan
- ADD 15,7 → ResultA=22, ResultB=0, Flags=0, Ready low exactly 1 cycle; ADD 200,100 → 44, C=1.
- SUB 7,15 → ResultA=248, C=1, N=1; EQU 9,9 → 255; GTH 15,7 → 255; GTH 7,15 → 0, Z=1.
- MUL 15,7 → ResultA=105, ResultB=0, Ready low WIDTH+1=9 cycles; MUL 255,255 → ResultA=1, ResultB=254, C=1.
- DIV 15,7 → ResultA=2, ResultB=1 in 9 cycles; DIV 15,0 → ResultA=255, ResultB=15, E=1, 1 busy cycle.
- ROL 0x81,1 → 0x03; SHR 0x80,9 (amount 1) → 0x40; illegal opcode 11111 → results unchanged, E=1.
- Rst asserted mid-MUL cycle 4 → all outputs 0, Ready=1 immediately; Start pulsed while busy → ignored, result of first op intact.
